// File: rtl/opbomp_pkg.sv
// opbomp_pkg: shared defaults and FSM state encoding for the OPBOMP projection stage
package opbomp_pkg;
  localparam int N_SAMPLES = 25;
  localparam int SAMPLE_W = 16;
  localparam int N_ATOMS = 64;
  localparam int PROJ_W = 32;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} proj_state_t;
endpackage

// File: rtl/projection_scheduler_if.sv
// projection_scheduler_if: control, atom-memory and result bundle of projection_scheduler
// master: pass launcher + atom memory (drives start, x, atom_data)
// slave: scheduler (drives busy, done, atom_rd_en, atom_addr, proj_valid, proj_idx, proj, best_idx, best_proj)
interface projection_scheduler_if #(
  parameter int N_SAMPLES = opbomp_pkg::N_SAMPLES,
  parameter int SAMPLE_W = opbomp_pkg::SAMPLE_W,
  parameter int N_ATOMS = opbomp_pkg::N_ATOMS,
  parameter int PROJ_W = opbomp_pkg::PROJ_W,
  parameter int ADDR_W = $clog2(N_ATOMS * N_SAMPLES),
  parameter int IDX_W = $clog2(N_ATOMS)
);
  logic start;
  logic [N_SAMPLES*SAMPLE_W-1:0] x;
  logic busy;
  logic done;
  logic atom_rd_en;
  logic [ADDR_W-1:0] atom_addr;
  logic [SAMPLE_W-1:0] atom_data;
  logic proj_valid;
  logic [IDX_W-1:0] proj_idx;
  logic signed [PROJ_W-1:0] proj;
  logic [IDX_W-1:0] best_idx;
  logic signed [PROJ_W-1:0] best_proj;
  modport master (output start, x, atom_data,
                  input busy, done, atom_rd_en, atom_addr, proj_valid, proj_idx, proj, best_idx, best_proj);
  modport slave (input start, x, atom_data,
                 output busy, done, atom_rd_en, atom_addr, proj_valid, proj_idx, proj, best_idx, best_proj);
endinterface

// File: rtl/proj_mac.sv
// proj_mac: time-shared signed MAC; loads on an atom's first sample, narrows to PROJ_W on its last
// Ports: clk, rst; i_clr clears the accumulator; i_en/i_first/i_last qualify i_a*i_b;
//        o_valid pulses with the registered narrowed projection o_proj.
// Build option PROJ_SAT_EN: saturate the narrowed projection instead of wrapping.
module proj_mac #(
  parameter int SAMPLE_W = 16,
  parameter int N_SAMPLES = 25,
  parameter int PROJ_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_first,
  input  logic i_last,
  input  logic signed [SAMPLE_W-1:0] i_a,
  input  logic signed [SAMPLE_W-1:0] i_b,
  output logic o_valid,
  output logic signed [PROJ_W-1:0] o_proj
);
  localparam int ACC_W = PROJ_W + $clog2(N_SAMPLES);
  logic signed [2*SAMPLE_W-1:0] w_prod;
  logic signed [ACC_W-1:0] r_acc, w_sum;
  logic signed [PROJ_W-1:0] w_narrow;
  always_comb begin
    w_prod = i_a * i_b;
    w_sum = i_first ? ACC_W'(w_prod) : r_acc + ACC_W'(w_prod);
`ifdef PROJ_SAT_EN
    // in range only when every bit above the PROJ_W sign bit matches it
    w_narrow = (&w_sum[ACC_W-1:PROJ_W-1] || ~|w_sum[ACC_W-1:PROJ_W-1]) ? w_sum[PROJ_W-1:0]
             : {w_sum[ACC_W-1], {(PROJ_W-1){~w_sum[ACC_W-1]}}};
`else
    w_narrow = w_sum[PROJ_W-1:0];
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      o_valid <= 1'b0;
      o_proj <= '0;
    end else begin
      o_valid <= i_en && i_last;
      if (i_clr) r_acc <= '0;
      else if (i_en) r_acc <= w_sum;
      if (i_en && i_last) o_proj <= w_narrow;
    end
  end
endmodule

// File: rtl/projection_scheduler.sv
// projection_scheduler: streams all atoms through one MAC, emits each projection and the largest-|proj| atom
// Ports: clk, rst (sync, active-high); bus (projection_scheduler_if.slave) carries start/x,
//        the atom memory read port and the projection/best results.
// Build option PROJ_SAT_EN (in proj_mac): saturating instead of wrapping projection narrowing.
module projection_scheduler #(
  parameter int N_SAMPLES = opbomp_pkg::N_SAMPLES,
  parameter int SAMPLE_W = opbomp_pkg::SAMPLE_W,
  parameter int N_ATOMS = opbomp_pkg::N_ATOMS,
  parameter int PROJ_W = opbomp_pkg::PROJ_W,
  parameter int ADDR_W = $clog2(N_ATOMS * N_SAMPLES),
  parameter int IDX_W = $clog2(N_ATOMS)
) (
  input logic clk,
  input logic rst,
  projection_scheduler_if.slave bus
);
  import opbomp_pkg::*;
  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_RUN = S_RUN;
  localparam logic [1:0] ST_FLUSH = S_FLUSH;
  localparam logic [1:0] ST_DONE = S_DONE;
  localparam int SI_W = $clog2(N_SAMPLES);
  logic [1:0] r_state;
  logic [N_SAMPLES*SAMPLE_W-1:0] r_x;
  logic [SI_W-1:0] r_samp, r_dsamp;
  logic [IDX_W-1:0] r_atom, r_datom;
  logic [ADDR_W-1:0] r_addr;
  logic r_dv;
  logic w_last_samp, w_last_atom, w_dlast;
  logic signed [SAMPLE_W-1:0] w_xs;
  // magnitude one bit wider so the most negative projection is exact
  function automatic logic [PROJ_W:0] f_mag(input logic [PROJ_W-1:0] v);
    return v[PROJ_W-1] ? -{1'b1, v} : {1'b0, v};
  endfunction
  // r_d* are the read-side counters delayed to line up with atom_data one cycle later
  assign w_last_samp = r_samp == SI_W'(N_SAMPLES - 1);
  assign w_last_atom = r_atom == IDX_W'(N_ATOMS - 1);
  assign w_dlast = r_dsamp == SI_W'(N_SAMPLES - 1);
  assign w_xs = r_x[int'(r_dsamp)*SAMPLE_W +: SAMPLE_W];
  assign bus.busy = r_state != ST_IDLE;
  assign bus.done = r_state == ST_DONE;
  assign bus.atom_rd_en = r_state == ST_RUN;
  assign bus.atom_addr = r_addr;
  proj_mac #(.SAMPLE_W(SAMPLE_W), .N_SAMPLES(N_SAMPLES), .PROJ_W(PROJ_W)) u_mac (
    .clk(clk),
    .rst(rst),
    .i_clr(bus.start && r_state == ST_IDLE),
    .i_en(r_dv),
    .i_first(r_dsamp == '0),
    .i_last(w_dlast),
    .i_a(w_xs),
    .i_b(bus.atom_data),
    .o_valid(bus.proj_valid),
    .o_proj(bus.proj)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_x <= '0;
      r_samp <= '0;
      r_atom <= '0;
      r_addr <= '0;
      r_dv <= 1'b0;
      r_dsamp <= '0;
      r_datom <= '0;
      bus.proj_idx <= '0;
      bus.best_idx <= '0;
      bus.best_proj <= '0;
    end else begin
      r_dv <= r_state == ST_RUN;
      r_dsamp <= r_samp;
      r_datom <= r_atom;
      if (r_dv && w_dlast) bus.proj_idx <= r_datom;
      // strictly greater, so ties keep the earlier (lower) index
      if (bus.proj_valid && f_mag(bus.proj) > f_mag(bus.best_proj)) begin
        bus.best_idx <= bus.proj_idx;
        bus.best_proj <= bus.proj;
      end
      case (r_state)
        ST_IDLE: begin
          r_samp <= '0;
          r_atom <= '0;
          r_addr <= '0;
          if (bus.start) begin
            r_state <= ST_RUN;
            r_x <= bus.x;
            bus.best_idx <= '0;
            bus.best_proj <= '0;
          end
        end
        ST_RUN: begin
          r_addr <= r_addr + ADDR_W'(1);
          r_samp <= w_last_samp ? '0 : r_samp + SI_W'(1);
          r_atom <= r_atom + IDX_W'(w_last_samp);
          if (w_last_samp && w_last_atom) r_state <= ST_FLUSH;
        end
        // only the final atom's projection can pulse while flushing
        ST_FLUSH: if (bus.proj_valid) r_state <= ST_DONE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_projection_scheduler.sv
// tb_projection_scheduler: directed checks of projection_scheduler against hand-computed results
module tb_projection_scheduler;
  localparam int NA = 64;
  localparam int NS = 25;
  localparam int NM = NA * NS;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  projection_scheduler_if bus ();
  projection_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  logic [15:0] mem [NM];
  int exp_p [NA];
  int vecs = 0;
  int errs = 0;
  int ecnt = 0;
  int s_edge = 0;
  int cyc = 0;
  logic mon_clr = 1'b0;
  int pv_cnt = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0, rd_cnt = 0, rd_bad = 0;
  logic [31:0] pv_val [NA];
  int pv_cyc [NA];
  logic [5:0] done_bidx = '0;
  logic [31:0] done_bproj = '0;

  always @(posedge clk) ecnt <= ecnt + 1;
  always @(posedge clk) if (bus.atom_rd_en) bus.atom_data <= mem[bus.atom_addr];

  always @(negedge clk) begin
    if (mon_clr) begin
      pv_cnt = 0; done_cnt = 0; done_cyc = 0; busy_cnt = 0; rd_cnt = 0; rd_bad = 0;
      for (int j = 0; j < NA; j++) begin pv_val[j] = 32'hDEADBEEF; pv_cyc[j] = 0; end
    end else begin
      cyc = ecnt - s_edge + 1;
      if (bus.busy) busy_cnt++;
      if (bus.atom_rd_en) begin
        if (int'(bus.atom_addr) != rd_cnt || cyc != rd_cnt + 1) rd_bad++;
        rd_cnt++;
      end
      if (bus.proj_valid) begin
        pv_cnt++;
        pv_val[bus.proj_idx] = bus.proj;
        pv_cyc[bus.proj_idx] = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        done_bidx = bus.best_idx;
        done_bproj = bus.best_proj;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start sampled at edge 0; sp: cycle of an extra start pulse; ra: cycle in which rst is raised
  task automatic run(input int sp, input int ra);
    @(posedge clk); #2 bus.start = 1'b1; mon_clr = 1'b1;
    @(posedge clk); #2 s_edge = ecnt; bus.start = 1'b0; mon_clr = 1'b0;
    for (int i = 0; i < NS; i++) bus.x[i*16 +: 16] = 16'($urandom);
    for (int c = 2; c <= 1620; c++) begin
      @(posedge clk); #2;
      bus.start = (c == sp);
      if (c == ra) begin
        rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        return;
      end
    end
  endtask

  task automatic chk_pass(input string tag, input logic [31:0] bi, input logic [31:0] bp);
    int tbad = 0;
    for (int j = 0; j < NA; j++) begin
      chk($sformatf("%s_proj%0d", tag, j), pv_val[j], 32'(exp_p[j]));
      if (pv_cyc[j] != (j + 1) * NS + 2) tbad++;
    end
    chk({tag, "_pv_cyc0"}, pv_cyc[0], 27);
    chk({tag, "_pv_cyc1"}, pv_cyc[1], 52);
    chk({tag, "_pv_cyc63"}, pv_cyc[63], 1602);
    chk({tag, "_pv_timing_bad"}, tbad, 0);
    chk({tag, "_pv_cnt"}, pv_cnt, 64);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_cyc"}, done_cyc, 1603);
    chk({tag, "_busy_cnt"}, busy_cnt, 1603);
    chk({tag, "_rd_cnt"}, rd_cnt, 1600);
    chk({tag, "_rd_bad"}, rd_bad, 0);
    chk({tag, "_best_idx"}, done_bidx, bi);
    chk({tag, "_best_proj"}, done_bproj, bp);
    chk({tag, "_hold_idx"}, bus.best_idx, bi);
    chk({tag, "_hold_proj"}, bus.best_proj, bp);
  endtask

  task automatic load_sign;
    for (int k = 0; k < NM; k++) mem[k] = '0;
    for (int j = 0; j < NA; j++) begin mem[j*NS] = 16'(j - 32); exp_p[j] = j - 32; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rd_en"}, bus.atom_rd_en, 0);
    chk({tag, "_addr"}, bus.atom_addr, 0);
    chk({tag, "_pv"}, bus.proj_valid, 0);
    chk({tag, "_pidx"}, bus.proj_idx, 0);
    chk({tag, "_proj"}, bus.proj, 0);
    chk({tag, "_bidx"}, bus.best_idx, 0);
    chk({tag, "_bproj"}, bus.best_proj, 0);
  endtask

  initial begin
    logic [31:0] sat_exp;
    bus.start = 1'b0;
    bus.x = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #2 rst = 1'b0;

    load_sign();
    bus.x = '0; bus.x[15:0] = 16'd1;
    run(0, 0);
    chk_pass("sign", 0, 32'hFFFFFFE0);

    for (int k = 0; k < NM; k++) mem[k] = 16'h7FFF;
    for (int i = 0; i < NS; i++) bus.x[i*16 +: 16] = 16'h7FFF;
`ifdef PROJ_SAT_EN
    sat_exp = 32'h7FFFFFFF;
`else
    sat_exp = 32'h3FE70019;
`endif
    for (int j = 0; j < NA; j++) exp_p[j] = int'(sat_exp);
    run(0, 0);
    chk_pass("sat", 0, sat_exp);

    for (int k = 0; k < NM; k++) mem[k] = '0;
    for (int j = 0; j < NA; j++) exp_p[j] = 0;
    mem[3*NS+2] = 16'd2; mem[3*NS+24] = 16'd3; mem[7*NS+2] = -16'sd5; mem[10*NS+5] = 16'h7FFF;
    exp_p[3] = 5; exp_p[7] = -5;
    bus.x = '0; bus.x[2*16 +: 16] = 16'd1; bus.x[24*16 +: 16] = 16'd1;
    run(500, 0);
    chk_pass("tie_busystart", 3, 5);

    load_sign();
    bus.x = '0; bus.x[15:0] = 16'd1;
    run(0, 800);
    @(negedge clk);
    chk_zero("midrst");
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("midrst_pv_cnt", pv_cnt, 31);
    chk("midrst_done_cnt", done_cnt, 0);
    chk("midrst_idle", bus.busy, 0);
    bus.x = '0; bus.x[15:0] = 16'd1;
    run(0, 0);
    chk_pass("rerun", 0, 32'hFFFFFFE0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/projection_scheduler.md
# projection_scheduler

Sequencer for the OPBOMP projection stage: latches one measurement vector `x`, streams every dictionary atom from an external synchronous atom memory, and computes all inner products on a single shared multiply-accumulate unit. It emits each atom's projection as it completes and reports the atom with the largest-magnitude projection. It sits between the measurement capture and the OPBOMP selection/update logic, replacing a fully parallel projection datapath with one time-shared MAC.

## Interface
- `N_SAMPLES`, 25: samples per vector/atom
- `SAMPLE_W`, 16: signed two's-complement sample width
- `N_ATOMS`, 64: dictionary size
- `PROJ_W`, 32: projection output width
- `ADDR_W`, clog2(N_ATOMS*N_SAMPLES): atom memory address width
- `IDX_W`, clog2(N_ATOMS): atom index width

- `clk`  in  1  the single clock; all logic on rising edge
- `rst`  in  1  reset, synchronous and active-high
- `start`  in  1  begin a pass; sampled only in IDLE
- `x`  in  N_SAMPLES*SAMPLE_W  measurement vector; sample i = `x[i*SAMPLE_W +: SAMPLE_W]`
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle pulse; best result valid
- `atom_rd_en`  out  1  atom memory read strobe
- `atom_addr`  out  ADDR_W  address j*N_SAMPLES + i
- `atom_data`  in  SAMPLE_W  read data, valid exactly 1 cycle after `atom_rd_en`
- `proj_valid`  out  1  one-cycle pulse per atom
- `proj_idx`  out  IDX_W  atom index of `proj`
- `proj`  out  PROJ_W  signed inner product of atom `proj_idx` with `x`
- `best_idx`  out  IDX_W  index of largest |proj|
- `best_proj`  out  PROJ_W  signed projection of `best_idx`

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: `start`=1 latches `x` into an internal register, clears accumulator and best magnitude, moves to RUN. Later changes to `x` have no effect on the pass.
- RUN: one read per cycle, atom-major, sample-minor, no bubbles; addresses 0 .. N_ATOMS*N_SAMPLES-1. After the last address is issued -> FLUSH.
- MAC: signed SAMPLE_W x SAMPLE_W product, accumulator PROJ_W+clog2(N_SAMPLES) bits (37 by default). The first sample of each atom loads the product rather than adding, so there is no clear bubble between atoms.
- On the last sample of atom j, the accumulator is narrowed to PROJ_W, see Configuration. `proj`, `proj_idx`=j, and `proj_valid` are registered.
- Best tracking: magnitude is computed in PROJ_W+1 bits, so |−2^31| is exact. The best entry updates only if strictly greater. Ties keep the lower index. The all-zero vector gives `best_idx`=0, `best_proj`=0.
- FLUSH: waits for the last projection and best update -> DONE.
- DONE: `done`=1 for one cycle -> IDLE.
- `start` while `busy` is ignored. `start` held high in IDLE on the cycle after DONE launches a new pass.
- `best_idx`/`best_proj` hold their values until the next `start` clears them.

## Timing
- `start` is sampled at edge 0. Atom j sample i is read during cycle 1 + j*N_SAMPLES + i.
- `proj_valid` for atom j is asserted during cycle (j+1)*N_SAMPLES + 2.
- `done` is asserted during cycle N_ATOMS*N_SAMPLES + 3, which is 1603 by default. `best_*` is already final in that cycle.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- Reset values: all outputs 0, state IDLE.
- `rst` mid-pass: the next edge returns to IDLE. All outputs go to 0, including `best_*`. In-flight `atom_data` is discarded. No `proj_valid` or `done` follows. `rst` has priority over `start`.

## Configuration
- `PROJ_SAT_EN` defined: the narrowed projection saturates to [−2^(PROJ_W−1), 2^(PROJ_W−1)−1].
- `PROJ_SAT_EN` undefined: the narrowed projection is the low PROJ_W bits (two's-complement wrap).
- The internal accumulator width is the same in both cases.

## Structure
- Package `opbomp_pkg`: default N_SAMPLES, SAMPLE_W, N_ATOMS, PROJ_W; state enum `proj_state_t`.
- Sub-module `proj_mac`: load/accumulate control, wide accumulator, narrowing/saturation. The scheduler owns the FSM, address counters, and best tracking.

## Test plan
- Sign and argmax:
  - Stimulus: `x` sample0=1, all other samples 0; atom j sample0 = j−32, other samples 0.
  - Required: `proj` for atom j = j−32; `best_idx`=0, `best_proj`=0xFFFFFFE0.
- Saturation:
  - Stimulus: all `x` and all atom samples 0x7FFF.
  - Required: `proj`=0x7FFFFFFF with `PROJ_SAT_EN`; 0x3FE70019 without.
- Tie:
  - Stimulus: atom 3 gives +5, atom 7 gives −5, all others 0.
  - Required: `best_idx`=3, `best_proj`=5.
- Timing:
  - Stimulus: a single pass at default parameters.
  - Required: `proj_valid` at cycles 27, 52, …; `done` at 1603; `busy` for 1603 cycles; reads contiguous.
- Start while busy:
  - Stimulus: `start` pulsed at cycle 500.
  - Required: ignored; exactly 64 `proj_valid` pulses and one `done`.
- Reset mid-pass:
  - Stimulus: `rst` at cycle 800, then `start`.
  - Required: all outputs 0 the next cycle; no `done` from the aborted pass; the new pass yields correct results at the standard timing.
